// File: rtl/ppu_interrupt_ctrl_if.sv
// Signal bundle between the PPU interrupt controller, its config/latch neighbours and the host TX byte stream.
// The slave view is the controller itself; the master view is whatever drives config, latch bits and tx_ready.
interface ppu_interrupt_ctrl_if;
  logic       cfg_wr_i;
  logic [1:0] cfg_addr_i;
  logic [7:0] cfg_data_i;
  logic [7:0] int_enabled_o;
  logic       int_clear_all_o;
  logic [7:0] int_triggered_i;
  logic       int_any_triggered_i;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;
  logic       busy_o;

  modport slave (
    input  cfg_wr_i, cfg_addr_i, cfg_data_i,
    input  int_triggered_i, int_any_triggered_i, tx_ready_i,
    output int_enabled_o, int_clear_all_o, tx_data_o, tx_valid_o, busy_o
  );

  modport master (
    output cfg_wr_i, cfg_addr_i, cfg_data_i,
    output int_triggered_i, int_any_triggered_i, tx_ready_i,
    input  int_enabled_o, int_clear_all_o, tx_data_o, tx_valid_o, busy_o
  );
endinterface

// File: rtl/ppu_interrupt_ctrl.sv
// PPU edge-interrupt controller: drives the enable mask, snapshots and clears latched bits,
// and reports each event as {OPCODE, bits, seq} on a byte stream, followed by a coalescing holdoff.
module ppu_interrupt_ctrl #(
  parameter logic [7:0]  OPCODE   = 8'hA5,
  parameter int unsigned TICK_DIV = 64
) (
  input  logic               clock,
  input  logic               reset,
  ppu_interrupt_ctrl_if.slave bus
);

  localparam int TD_W  = $clog2(TICK_DIV + 1);
  localparam int CNT_W = (8 + TD_W > 16) ? (8 + TD_W) : 16;
  localparam logic [CNT_W-1:0] TICK_C = CNT_W'(TICK_DIV);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_BITS, S_SEQ, S_HOLD} state_e;

  state_e           state_q, state_d;
  logic [7:0]       mask_q, holdoff_q;
  logic             global_en_q;
  logic [7:0]       snap_q, snap_d;
  logic [7:0]       seq_q, seq_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_load;
  logic             start;
  logic             force_clear;
  logic             tx_valid;
  logic [7:0]       tx_data;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      mask_q      <= 8'h00;
      holdoff_q   <= 8'h00;
      global_en_q <= 1'b0;
    end else if (bus.cfg_wr_i) begin
      case (bus.cfg_addr_i)
        2'd0:    mask_q      <= bus.cfg_data_i;
        2'd1:    holdoff_q   <= bus.cfg_data_i;
        2'd2:    global_en_q <= bus.cfg_data_i[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      snap_q  <= 8'h00;
      seq_q   <= 8'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt_load = CNT_W'(holdoff_q) * TICK_C - CNT_W'(1);

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    seq_d    = seq_q;
    cnt_d    = cnt_q;
    start    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (global_en_q && bus.int_any_triggered_i) begin
          start   = 1'b1;
          snap_d  = bus.int_triggered_i;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = OPCODE;
        if (bus.tx_ready_i) state_d = S_BITS;
      end
      S_BITS: begin
        tx_valid = 1'b1;
        tx_data  = snap_q;
        if (bus.tx_ready_i) state_d = S_SEQ;
      end
      S_SEQ: begin
        tx_valid = 1'b1;
        tx_data  = seq_q;
        if (bus.tx_ready_i) begin
          seq_d = seq_q + 8'd1;
          if (holdoff_q == 8'd0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_load;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // Latched bits keep accumulating here; nothing is snapped or cleared.
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign force_clear = bus.cfg_wr_i && (bus.cfg_addr_i == 2'd2) && bus.cfg_data_i[1];

  assign bus.int_clear_all_o = !reset && (force_clear || start);
  assign bus.int_enabled_o   = global_en_q ? mask_q : 8'h00;
  assign bus.tx_valid_o      = tx_valid;
  assign bus.tx_data_o       = tx_data;
  assign bus.busy_o          = (state_q != S_IDLE);

endmodule
